// File: rtl/reg_stack_arbiter.sv
// rtl/reg_stack_arbiter.sv - two-requester access arbiter for the 32x32 register stack port
// Optional feature macro: REG_ARB_ROUND_ROBIN_EN (defined: round-robin, undefined: requester 0 priority).
// Each access runs IDLE -> ACCESS -> ACK; all outputs are registered.
module reg_stack_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req_0,
  input  logic              Req_1,
  input  logic              Wr_0,
  input  logic              Wr_1,
  input  logic [ADDR_W-1:0] Addr_0,
  input  logic [ADDR_W-1:0] Addr_1,
  input  logic [DATA_W-1:0] Data_0,
  input  logic [DATA_W-1:0] Data_1,
  output logic              Ack_0,
  output logic              Ack_1,
  output logic [DATA_W-1:0] R_Data_0,
  output logic [DATA_W-1:0] R_Data_1,
  output logic              Write_Reg,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic [ADDR_W-1:0] R_Addr_A,
  input  logic [DATA_W-1:0] R_Data_A,
  output logic              Busy,
  output logic              Last_Grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                write_reg_q, write_reg_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                last_grant_q, last_grant_d;
  logic                win;

  // Arbitration: pick the requester served when leaving IDLE.
  always_comb begin
    win = 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
    if (Req_0 && Req_1) begin
      win = ~last_grant_q;
    end else begin
      win = Req_1;
    end
`else
    win = ~Req_0;
`endif
  end

  // Next-state and next-output computation for the three-state transaction.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    write_reg_d  = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (Req_0 || Req_1) begin
          sel_d       = win;
          wr_d        = win ? Wr_1 : Wr_0;
          addr_d      = win ? Addr_1 : Addr_0;
          data_d      = win ? Data_1 : Data_0;
          write_reg_d = win ? Wr_1 : Wr_0;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (!wr_q && !sel_q) rdata0_d = R_Data_A;
        if (!wr_q && sel_q)  rdata1_d = R_Data_A;
        ack0_d       = ~sel_q;
        ack1_d       = sel_q;
        last_grant_d = sel_q;
        busy_d       = 1'b1;
        state_d      = ACK;
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      write_reg_q  <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_reg_q  <= write_reg_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign Ack_0      = ack0_q;
  assign Ack_1      = ack1_q;
  assign R_Data_0   = rdata0_q;
  assign R_Data_1   = rdata1_q;
  assign Write_Reg  = write_reg_q;
  assign W_Addr     = addr_q;
  assign R_Addr_A   = addr_q;
  assign W_Data     = data_q;
  assign Busy       = busy_q;
  assign Last_Grant = last_grant_q;

endmodule

// File: tb/tb_reg_stack_arbiter.sv
// tb/tb_reg_stack_arbiter.sv - self-checking bench for reg_stack_arbiter with a register stack model
module tb_reg_stack_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req_0, Req_1, Wr_0, Wr_1;
  logic [4:0]  Addr_0, Addr_1;
  logic [31:0] Data_0, Data_1;
  logic        Ack_0, Ack_1;
  logic [31:0] R_Data_0, R_Data_1;
  logic        Write_Reg;
  logic [4:0]  W_Addr, R_Addr_A;
  logic [31:0] W_Data, R_Data_A;
  logic        Busy, Last_Grant;

  int checks = 0;
  int errors = 0;

  reg_stack_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req_0(Req_0), .Req_1(Req_1), .Wr_0(Wr_0), .Wr_1(Wr_1),
    .Addr_0(Addr_0), .Addr_1(Addr_1), .Data_0(Data_0), .Data_1(Data_1),
    .Ack_0(Ack_0), .Ack_1(Ack_1), .R_Data_0(R_Data_0), .R_Data_1(R_Data_1),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .R_Addr_A(R_Addr_A),
    .R_Data_A(R_Data_A), .Busy(Busy), .Last_Grant(Last_Grant)
  );

  always #5 CLK = ~CLK;

  // Register stack model: contents reset to C0DE0000|index, synchronous write, combinational read.
  logic [31:0] mem [0:31];
  always @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE0000 | i;
    end else if (Write_Reg) begin
      mem[W_Addr] <= W_Data;
    end
  end
  assign R_Data_A = mem[R_Addr_A];

  typedef struct {
    int          port;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

`ifdef REG_ARB_ROUND_ROBIN_EN
  localparam int FIRST_WIN = 1;
`else
  localparam int FIRST_WIN = 0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int port, output int cyc, output int wcnt,
                          output logic [4:0] wa, output logic [31:0] wd);
    port = -1; cyc = 0; wcnt = 0; wa = '0; wd = '0;
    while (port < 0 && cyc < 12) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      if (Write_Reg) begin
        wcnt++;
        wa = W_Addr;
        wd = W_Data;
      end
      if (Ack_0 && Ack_1) port = 2;
      else if (Ack_0) port = 0;
      else if (Ack_1) port = 1;
    end
  endtask

  task automatic set_port(input int p, input logic rq, input logic wr,
                          input logic [4:0] a, input logic [31:0] d);
    if (p == 0) begin
      Req_0 = rq; Wr_0 = wr; Addr_0 = a; Data_0 = d;
    end else begin
      Req_1 = rq; Wr_1 = wr; Addr_1 = a; Data_1 = d;
    end
  endtask

  task automatic run_txn(input string name, input int p, input logic wr,
                         input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    int port, cyc, wcnt;
    logic [4:0] wa;
    logic [31:0] wd;
    set_port(p, 1'b1, wr, a, d);
    wait_ack(port, cyc, wcnt, wa, wd);
    chk({name, " grant"}, port, p);
    chk({name, " latency"}, cyc, 2);
    chk({name, " write_reg cycles"}, wcnt, {31'd0, wr});
    if (wr) begin
      chk({name, " w_addr"}, wa, a);
      chk({name, " w_data"}, wd, d);
    end
    chk({name, " last_grant"}, Last_Grant, p);
    chk({name, " busy in ack"}, Busy, 1);
    chk({name, " r_data"}, (p == 0) ? R_Data_0 : R_Data_1, exp_rd);
    set_port(p, 1'b0, 1'b0, '0, '0);
    @(posedge CLK);
    @(negedge CLK);
    chk({name, " idle busy"}, Busy, 0);
  endtask

  initial begin
    int port, cyc, wcnt, seen;
    logic [4:0] wa;
    logic [31:0] wd;
    int exp_g [4];

    tbl[0] = '{0, 1'b1, 5'd3,  32'h55555555, 32'hC0DE0007};
    tbl[1] = '{0, 1'b0, 5'd3,  32'h0,        32'h55555555};
    tbl[2] = '{1, 1'b1, 5'd0,  32'hDEADBEEF, 32'hC0DE0009};
    tbl[3] = '{1, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF};
    tbl[4] = '{0, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF};
    tbl[5] = '{1, 1'b1, 5'd31, 32'h00000001, 32'hDEADBEEF};
    tbl[6] = '{0, 1'b0, 5'd31, 32'h0,        32'h00000001};
    tbl[7] = '{1, 1'b0, 5'd3,  32'h0,        32'h55555555};

    // Reset with both requests pending
    Reset = 1'b0;
    Req_0 = 1'b1; Wr_0 = 1'b0; Addr_0 = 5'd7; Data_0 = '0;
    Req_1 = 1'b1; Wr_1 = 1'b0; Addr_1 = 5'd9; Data_1 = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset write_reg", Write_Reg, 0);
    chk("reset w_addr", W_Addr, 0);
    chk("reset w_data", W_Data, 0);
    chk("reset r_addr_a", R_Addr_A, 0);
    chk("reset acks", {Ack_0, Ack_1}, 0);
    chk("reset r_data_0", R_Data_0, 0);
    chk("reset r_data_1", R_Data_1, 0);
    chk("reset busy", Busy, 0);
    chk("reset last_grant", Last_Grant, 0);
    Reset = 1'b1;
    wait_ack(port, cyc, wcnt, wa, wd);
    chk("first grant", port, FIRST_WIN);
    chk("first latency", cyc, 2);
    chk("first r_data", (FIRST_WIN == 1) ? R_Data_1 : R_Data_0,
        (FIRST_WIN == 1) ? 32'hC0DE0009 : 32'hC0DE0007);
    set_port(FIRST_WIN, 1'b0, 1'b0, '0, '0);
    wait_ack(port, cyc, wcnt, wa, wd);
    chk("second grant", port, 1 - FIRST_WIN);
    chk("second latency", cyc, 3);
    chk("r_data_0 addr7", R_Data_0, 32'hC0DE0007);
    chk("r_data_1 addr9", R_Data_1, 32'hC0DE0009);
    chk("last_grant after pair", Last_Grant, 1 - FIRST_WIN);
    set_port(1 - FIRST_WIN, 1'b0, 1'b0, '0, '0);
    @(posedge CLK);
    @(negedge CLK);

    // Single-requester vectors
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rd);
    end

    // Contention: both hold requests; Last_Grant is 1 here
`ifdef REG_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    set_port(0, 1'b1, 1'b1, 5'd5, 32'h11111111);
    set_port(1, 1'b1, 1'b0, 5'd5, 32'h0);
    for (int g = 0; g < 4; g++) begin
      wait_ack(port, cyc, wcnt, wa, wd);
      chk($sformatf("contention grant%0d", g), port, exp_g[g]);
      if (port == 1) chk($sformatf("contention r_data_1 %0d", g), R_Data_1, 32'h11111111);
    end
`ifndef REG_ARB_ROUND_ROBIN_EN
    Req_0 = 1'b0;
    wait_ack(port, cyc, wcnt, wa, wd);
    chk("fixed late grant", port, 1);
    chk("fixed r_data_1", R_Data_1, 32'h11111111);
`endif
    Req_0 = 1'b0; Req_1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);

    // Early request drop during ACCESS
    set_port(1, 1'b1, 1'b1, 5'd31, 32'hA1EDB736);
    @(posedge CLK);
    @(negedge CLK);
    chk("early drop in access", {Busy, Write_Reg}, 2'b11);
    Req_1 = 1'b0;
    wait_ack(port, cyc, wcnt, wa, wd);
    chk("early drop ack", port, 1);
    @(posedge CLK);
    @(negedge CLK);
    run_txn("readback31", 0, 1'b0, 5'd31, 32'h0, 32'hA1EDB736);

    // Reset asserted during ACCESS of a write
    set_port(0, 1'b1, 1'b1, 5'd12, 32'h12345678);
    @(posedge CLK);
    @(negedge CLK);
    chk("midreset access write_reg", Write_Reg, 1);
    #2 Reset = 1'b0;
    #1;
    chk("midreset write_reg drop", Write_Reg, 0);
    chk("midreset busy drop", Busy, 0);
    Req_0 = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (Ack_0 || Ack_1) seen++;
    end
    Reset = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      if (Ack_0 || Ack_1 || Busy) seen++;
    end
    chk("midreset no ack, idle", seen, 0);
    chk("midreset r_data_0 cleared", R_Data_0, 0);
    run_txn("post reset read", 1, 1'b0, 5'd3, 32'h0, 32'hC0DE0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
